pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 33 +++
 rtl/pc_gen_fsm.sv | 70 +++++++
 rtl/pc_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
// Shared types and constants for the program-counter generator.
//   pc_state_e      : BOOT / RUN / HALT fetch states
//   INC_STD/INC_RVC : sequential increments for 32-bit and 16-bit instructions
//   tgt_misaligned  : alignment check on a redirect target's low bits
// Configuration macro: PC_GEN_RVC_EN (compressed-instruction support).
// -----------------------------------------------------------------------------
package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   localparam int unsigned INC_STD    = 4;
   localparam int unsigned INC_RVC    = 2;
   localparam int unsigned BOOT_CNT_W = 4;

   // With compressed instructions a target only has to be halfword aligned;
   // without them it must be word aligned.
   function automatic logic tgt_misaligned(input logic [1:0] lsb);
`ifdef PC_GEN_RVC_EN
      logic unused_lsb1;
      unused_lsb1 = lsb[1];
      return lsb[0];
`else
      return |lsb;
`endif
   endfunction

endpackage

// File: rtl/pc_gen_fsm.sv
// -----------------------------------------------------------------------------
// pc_gen_fsm
// Fetch control state machine: holds the BOOT/RUN/HALT state and the boot
// delay counter. fetch_valid is registered and is high exactly in RUN.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   halt_req    in   pulse: leave RUN for HALT
//   resume      in   pulse: leave HALT for RUN (wins over halt_req)
//   state       out  current state
//   fetch_valid out  registered, high only in RUN
// -----------------------------------------------------------------------------
module pc_gen_fsm
   import pc_gen_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      halt_req,
   input  logic      resume,
   output pc_state_e state,
   output logic      fetch_valid
);

   localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES);

   logic [BOOT_CNT_W-1:0] boot_cnt;

   // The counter has already counted BOOT_CYCLES idle edges when it equals
   // BOOT_LAST, so the following edge enters RUN; with zero boot cycles the
   // very first edge does.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= BOOT;
         boot_cnt    <= '0;
         fetch_valid <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               if (boot_cnt == BOOT_LAST) begin
                  state       <= RUN;
                  fetch_valid <= 1'b1;
               end else begin
                  boot_cnt <= boot_cnt + 4'd1;
               end
            end
            RUN: begin
               if (halt_req) begin
                  state       <= HALT;
                  fetch_valid <= 1'b0;
               end
            end
            HALT: begin
               // resume takes precedence over a coincident halt_req
               if (resume) begin
                  state       <= RUN;
                  fetch_valid <= 1'b1;
               end
            end
            default: begin
               state       <= BOOT;
               boot_cnt    <= '0;
               fetch_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Program-counter generator. Holds the fetch PC, selects between trap vector,
// redirect target and sequential advance, and flags misaligned redirects.
// Configuration macro: PC_GEN_RVC_EN -- when defined, the increment is 2 for
// compressed instructions and redirect targets need only halfword alignment.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   fetch_ready  in   instruction memory accepts pc
//   redirect     in   branch/jump taken
//   redirect_tgt in   redirect target address
//   trap         in   exception/interrupt request (highest priority)
//   halt_req     in   pulse: halt fetching
//   resume       in   pulse: resume fetching
//   inst_is_rvc  in   current instruction is 16-bit (RVC builds only)
//   pc           out  registered fetch address
//   pc_seq       out  pc + increment, combinational, wraps modulo 2^XLEN
//   fetch_valid  out  pc is a valid fetch request
//   misalign_err out  one-cycle pulse after a misaligned redirect
// -----------------------------------------------------------------------------
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100),
   parameter int unsigned     BOOT_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_ready,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_tgt,
   input  logic            trap,
   input  logic            halt_req,
   input  logic            resume,
   input  logic            inst_is_rvc,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_seq,
   output logic            fetch_valid,
   output logic            misalign_err
);

   pc_state_e       state;
   logic [XLEN-1:0] inc;
   logic            tgt_bad;

   pc_gen_fsm #(
      .BOOT_CYCLES (BOOT_CYCLES)
   ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .halt_req    (halt_req),
      .resume      (resume),
      .state       (state),
      .fetch_valid (fetch_valid)
   );

`ifdef PC_GEN_RVC_EN
   always_comb begin
      inc = inst_is_rvc ? XLEN'(INC_RVC) : XLEN'(INC_STD);
   end
`else
   logic unused_rvc;
   assign unused_rvc = inst_is_rvc;
   always_comb begin
      inc = XLEN'(INC_STD);
   end
`endif

   // XLEN-wide add discards the carry, giving the modulo-2^XLEN wrap.
   assign pc_seq  = pc + inc;
   assign tgt_bad = tgt_misaligned(redirect_tgt[1:0]);

   // PC update: trap, then redirect, then sequential advance. Everything is
   // ignored in BOOT so pc stays at RESET_VEC until fetching starts. Trap and
   // redirect still act in HALT; advance needs fetch_valid, i.e. RUN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc           <= RESET_VEC;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= 1'b0;
         if (state != BOOT) begin
            if (trap) begin
               pc <= TRAP_VEC;
            end else if (redirect) begin
               if (tgt_bad) begin
                  pc           <= TRAP_VEC;
                  misalign_err <= 1'b1;
               end else begin
                  pc <= redirect_tgt;
               end
            end else if (fetch_valid && fetch_ready) begin
               pc <= pc_seq;
            end
         end
      end
   end

endmodule
